m_pwm_fader: RTL and testbench

//  Duty-value generator feeding m_pwm.value; replaces the raw up/down counter.

---
 rtl/m_pwm_fader.sv | 180 ++++++++++++++++++
 tb/tb_m_pwm_fader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/m_pwm_fader.sv
// Duty-value generator for m_pwm: manual up/down stepping with hold auto-repeat,
// or a continuous 0..255..0 breathe ramp, paced by the synchronised 10 ms tick.
module m_pwm_fader #(
    parameter int unsigned STEP         = 1,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       up,
    input  logic       down,
    input  logic       mode,
    output logic [7:0] duty,
    output logic       at_max,
    output logic       at_min,
    output logic [2:0] state
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);

    typedef enum logic [2:0] {
        MAN_IDLE   = 3'd0,
        MAN_HOLD   = 3'd1,
        MAN_REPEAT = 3'd2,
        BR_UP      = 3'd3,
        BR_DOWN    = 3'd4
    } state_e;

    // Synchroniser bit order: {mode, down, up, tick_in}
    logic [3:0]        sync1_q, sync2_q;
    logic              tick_prev_q, inc_prev_q, dec_prev_q;
    logic              dir_up_q, dir_up_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_inc;
    logic [7:0]        duty_q, duty_d;
    logic              at_max_q, at_min_q;
    state_e            state_q, state_d, br_entry;

    logic       tick_s, up_s, down_s, mode_s;
    logic       tick_p, inc, dec, inc_rise, dec_rise, held;
    logic       step_up, step_dn;
    logic [8:0] sum9, diff9;
    logic [7:0] up_sat, dn_sat;

    assign tick_s = sync2_q[0];
    assign up_s   = sync2_q[1];
    assign down_s = sync2_q[2];
    assign mode_s = sync2_q[3];

    assign tick_p   = tick_s & ~tick_prev_q;
    assign inc      = up_s & ~down_s;
    assign dec      = down_s & ~up_s;
    assign inc_rise = inc & ~inc_prev_q;
    assign dec_rise = dec & ~dec_prev_q;
    assign held     = dir_up_q ? inc : dec;

    // Saturating 9-bit step arithmetic; a borrow in diff9 means underflow.
    assign sum9   = {1'b0, duty_q} + 9'(STEP);
    assign diff9  = {1'b0, duty_q} - 9'(STEP);
    assign up_sat = sum9[8] ? 8'hFF : sum9[7:0];
    assign dn_sat = diff9[8] ? 8'h00 : diff9[7:0];

    assign hold_inc = hold_cnt_q + HOLD_W'(1);
    assign rep_inc  = rep_cnt_q + REP_W'(1);
    assign br_entry = (duty_q == 8'hFF) ? BR_DOWN : BR_UP;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        dir_up_d   = dir_up_q;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        unique case (state_q)
            MAN_IDLE: begin
                if (mode_s) begin
                    state_d = br_entry;
                end else if (inc_rise || dec_rise) begin
                    step_up    = inc_rise;
                    step_dn    = dec_rise;
                    dir_up_d   = inc_rise;
                    hold_cnt_d = '0;
                    state_d    = MAN_HOLD;
                end
            end
            MAN_HOLD: begin
                if (mode_s) begin
                    state_d = br_entry;
                end else if (!held) begin
                    state_d = MAN_IDLE;
                end else if (tick_p) begin
                    if (hold_inc == HOLD_W'(HOLD_TICKS)) begin
                        step_up   = dir_up_q;
                        step_dn   = ~dir_up_q;
                        rep_cnt_d = '0;
                        state_d   = MAN_REPEAT;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
            end
            MAN_REPEAT: begin
                if (mode_s) begin
                    state_d = br_entry;
                end else if (!held) begin
                    state_d = MAN_IDLE;
                end else if (tick_p) begin
                    if (rep_inc == REP_W'(REPEAT_TICKS)) begin
                        step_up   = dir_up_q;
                        step_dn   = ~dir_up_q;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
                end
            end
            BR_UP: begin
                if (!mode_s) begin
                    state_d = MAN_IDLE;
                end else if (tick_p) begin
                    step_up = 1'b1;
                    if (up_sat == 8'hFF) state_d = BR_DOWN;
                end
            end
            BR_DOWN: begin
                if (!mode_s) begin
                    state_d = MAN_IDLE;
                end else if (tick_p) begin
                    step_dn = 1'b1;
                    if (dn_sat == 8'h00) state_d = BR_UP;
                end
            end
            default: state_d = MAN_IDLE;
        endcase
    end

    always_comb begin
        duty_d = duty_q;
        if (step_up)      duty_d = up_sat;
        else if (step_dn) duty_d = dn_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tick_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
            dir_up_q    <= 1'b0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            duty_q      <= 8'h00;
            at_max_q    <= 1'b0;
            at_min_q    <= 1'b1;
            state_q     <= MAN_IDLE;
        end else begin
            sync1_q     <= {mode, down, up, tick_in};
            sync2_q     <= sync1_q;
            tick_prev_q <= tick_s;
            inc_prev_q  <= inc;
            dec_prev_q  <= dec;
            dir_up_q    <= dir_up_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            duty_q      <= duty_d;
            at_max_q    <= (duty_d == 8'hFF);
            at_min_q    <= (duty_d == 8'h00);
            state_q     <= state_d;
        end
    end

    assign duty   = duty_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign state  = state_q;

endmodule

// File: tb/tb_m_pwm_fader.sv
// Directed bench for m_pwm_fader: three instances with different STEP values
// share one stimulus; each scenario checks the instance it targets.
module tb_m_pwm_fader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] duty_a, duty_b, duty_c;
    logic       max_a, max_b, max_c, min_a, min_b, min_c;
    logic [2:0] st_a, st_b, st_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    m_pwm_fader #(.STEP(1), .HOLD_TICKS(50), .REPEAT_TICKS(5)) u_a (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .up(up), .down(down), .mode(mode),
        .duty(duty_a), .at_max(max_a), .at_min(min_a), .state(st_a));
    m_pwm_fader #(.STEP(4), .HOLD_TICKS(50), .REPEAT_TICKS(5)) u_b (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .up(up), .down(down), .mode(mode),
        .duty(duty_b), .at_max(max_b), .at_min(min_b), .state(st_b));
    m_pwm_fader #(.STEP(5), .HOLD_TICKS(50), .REPEAT_TICKS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .up(up), .down(down), .mode(mode),
        .duty(duty_c), .at_max(max_c), .at_min(min_c), .state(st_c));

    typedef struct {
        logic up;
        logic down;
        logic mode;
        int   ticks;
        int   duty;
        int   st;
        logic amax;
        logic amin;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick = one rising edge of tick_in; 8 clk period leaves room for the 3-cycle latency.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc(4);
            tick_in = 1'b0;
            cyc(4);
        end
    endtask

    task automatic set_in(input logic u, input logic d, input logic m);
        up = u; down = d; mode = m;
        cyc(4);
    endtask

    task automatic do_reset();
        up = 1'b0; down = 1'b0; mode = 1'b0; tick_in = 1'b0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic chk_a(input string tag, input int d, input int s, input int mx, input int mn);
        check({tag, ".duty"},   int'(duty_a), d);
        check({tag, ".state"},  int'(st_a), s);
        check({tag, ".at_max"}, int'(max_a), mx);
        check({tag, ".at_min"}, int'(min_a), mn);
    endtask

    initial begin
        // up, down, mode, ticks -> duty, state, at_max, at_min  (instance A, STEP=1)
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0,   0,   0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1,   1,   1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0,   1,   0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2,   1,   0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 0,   0,   1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 0,   0,   0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 0,   0,   1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 0,   0,   0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 120, 120, 3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3,   120, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 0,   121, 1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 0,   121, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 0,   121, 3, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 2,   123, 3, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 0,   123, 0, 1'b0, 1'b0};

        // Reset state, all instances
        cyc(2);
        chk_a("rst", 0, 0, 0, 1);
        check("rst.b.duty", int'(duty_b), 0);
        check("rst.c.min", int'(min_c), 1);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].up, vecs[i].down, vecs[i].mode);
            do_ticks(vecs[i].ticks);
            chk_a($sformatf("vec%0d", i), vecs[i].duty, vecs[i].st,
                  int'(vecs[i].amax), int'(vecs[i].amin));
        end

        // Async reset in the middle of a breathe ramp, then no step on release
        do_reset();
        set_in(1'b0, 1'b0, 1'b1);
        do_ticks(100);
        check("t1.pre.duty", int'(duty_a), 100);
        rst_n = 1'b0;
        #1;
        chk_a("t1.async", 0, 0, 0, 1);
        mode = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk_a("t1.release", 0, 0, 0, 1);

        // Hold and auto-repeat: press step, hold step at 50, repeats at 55/60/65/70
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        chk_a("t3.press", 1, 1, 0, 0);
        do_ticks(49);
        chk_a("t3.h49", 1, 1, 0, 0);
        do_ticks(1);
        chk_a("t3.h50", 2, 2, 0, 0);
        do_ticks(4);
        check("t3.r54.duty", int'(duty_a), 2);
        do_ticks(1);
        check("t3.r55.duty", int'(duty_a), 3);
        do_ticks(15);
        chk_a("t3.h70", 6, 2, 0, 0);
        set_in(1'b0, 1'b0, 1'b0);
        chk_a("t3.rel", 6, 0, 0, 0);

        // Saturation on instance B (STEP=4): 252+4 clamps to 255, 3-4 clamps to 0
        do_reset();
        set_in(1'b0, 1'b0, 1'b1);
        do_ticks(63);
        check("t4.ramp.duty", int'(duty_b), 252);
        check("t4.ramp.state", int'(st_b), 3);
        set_in(1'b0, 1'b0, 1'b0);
        check("t4.man.state", int'(st_b), 0);
        set_in(1'b1, 1'b0, 1'b0);
        check("t4.up.duty", int'(duty_b), 255);
        check("t4.up.max", int'(max_b), 1);
        set_in(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0);
        check("t4.up2.duty", int'(duty_b), 255);
        set_in(1'b0, 1'b0, 1'b1);
        check("t4.br255.state", int'(st_b), 4);
        do_ticks(63);
        check("t4.fall.duty", int'(duty_b), 3);
        set_in(1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 1'b0);
        check("t4.dn.duty", int'(duty_b), 0);
        check("t4.dn.min", int'(min_b), 1);
        check("t4.dn.max", int'(max_b), 0);
        set_in(1'b0, 1'b0, 1'b0);

        // Breathe on instance C (STEP=5): 255 after 51 ticks, 0 after 102
        do_reset();
        set_in(1'b0, 1'b0, 1'b1);
        do_ticks(50);
        check("t5.t50.duty", int'(duty_c), 250);
        check("t5.t50.max", int'(max_c), 0);
        do_ticks(1);
        check("t5.t51.duty", int'(duty_c), 255);
        check("t5.t51.max", int'(max_c), 1);
        check("t5.t51.state", int'(st_c), 4);
        do_ticks(1);
        check("t5.t52.duty", int'(duty_c), 250);
        check("t5.t52.max", int'(max_c), 0);
        do_ticks(49);
        check("t5.t101.duty", int'(duty_c), 5);
        check("t5.t101.min", int'(min_c), 0);
        do_ticks(1);
        check("t5.t102.duty", int'(duty_c), 0);
        check("t5.t102.min", int'(min_c), 1);
        check("t5.t102.state", int'(st_c), 3);
        do_ticks(1);
        check("t5.t103.duty", int'(duty_c), 5);
        check("t5.t103.min", int'(min_c), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
